// File: rtl/rom_msg_streamer.sv
// Walks a segment of the 64x8 ASCII string ROM and streams each byte
// on a valid/ready interface, inserting a space between segments in full mode.
module rom_msg_streamer #(
    parameter int                ADDR_W     = 6,
    parameter int                DATA_W     = 8,
    parameter logic [ADDR_W-1:0] SPACE_ADDR = ADDR_W'('h2F)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        sel,
    output logic              busy,
    output logic              err,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, SEND} state_t;

    localparam logic [2:0] SEL_FULL = 3'd5;
    localparam logic [2:0] SEG_LAST = 3'd4;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              valid_nxt, busy_nxt, done_nxt, err_nxt;
    logic [2:0]        seg, seg_nxt;
    logic [3:0]        chr, chr_nxt;
    logic              full, full_nxt;
    logic              space_pend, space_pend_nxt;

    function automatic logic [ADDR_W-1:0] seg_base(input logic [2:0] s);
        case (s)
            3'd0:    return ADDR_W'('h00);
            3'd1:    return ADDR_W'('h09);
            3'd2:    return ADDR_W'('h0F);
            3'd3:    return ADDR_W'('h1D);
            3'd4:    return ADDR_W'('h25);
            default: return '0;
        endcase
    endfunction

    // Index of the final character in each segment.
    function automatic logic [3:0] seg_end(input logic [2:0] s);
        case (s)
            3'd0:    return 4'd8;
            3'd1:    return 4'd5;
            3'd2:    return 4'd6;
            3'd3:    return 4'd7;
            3'd4:    return 4'd6;
            default: return 4'd0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rom_addr   <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            seg        <= '0;
            chr        <= '0;
            full       <= 1'b0;
            space_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            rom_addr   <= addr_nxt;
            tx_data    <= data_nxt;
            tx_valid   <= valid_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            seg        <= seg_nxt;
            chr        <= chr_nxt;
            full       <= full_nxt;
            space_pend <= space_pend_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        addr_nxt       = rom_addr;
        data_nxt       = tx_data;
        valid_nxt      = tx_valid;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        err_nxt        = 1'b0;
        seg_nxt        = seg;
        chr_nxt        = chr;
        full_nxt       = full;
        space_pend_nxt = space_pend;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (sel <= SEL_FULL) begin
                        busy_nxt       = 1'b1;
                        full_nxt       = (sel == SEL_FULL);
                        seg_nxt        = (sel == SEL_FULL) ? 3'd0 : sel;
                        chr_nxt        = '0;
                        space_pend_nxt = 1'b0;
                        addr_nxt       = seg_base(seg_nxt);
                        state_nxt      = FETCH;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            FETCH: state_nxt = LOAD;
            LOAD: begin
                data_nxt  = rom_data;
                valid_nxt = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = FETCH;
                    if (space_pend) begin
                        space_pend_nxt = 1'b0;
                        seg_nxt        = seg + 3'd1;
                        chr_nxt        = '0;
                        addr_nxt       = seg_base(seg + 3'd1);
                    end else if (chr == seg_end(seg)) begin
                        if (full && seg != SEG_LAST) begin
                            space_pend_nxt = 1'b1;
                            addr_nxt       = SPACE_ADDR;
                        end else begin
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        chr_nxt  = chr + 4'd1;
                        addr_nxt = rom_addr + ADDR_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
